// File: rtl/sext_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sext_arbiter
//  Purpose  : Shares one sign/zero-extension unit between two pipeline
//             requesters (0 = ID-stage immediates, 1 = MEM-stage narrow load
//             data). Round-robin grant feeds a one-entry registered output
//             with a valid/ready handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    IN_W         width of the narrow operand
//    OUT_W        width of the extended result (must be > IN_W)
//  Ports
//    clk          system clock, rising edge
//    rst          asynchronous, active-high reset
//    req0_valid   requester 0 has an operand
//    req0_data    requester 0 operand            [IN_W-1:0]
//    req0_signed  requester 0: 1 = sign-extend, 0 = zero-extend
//    req0_ready   requester 0 operand accepted this cycle
//    req1_valid   requester 1 has an operand
//    req1_data    requester 1 operand            [IN_W-1:0]
//    req1_signed  requester 1: 1 = sign-extend, 0 = zero-extend
//    req1_ready   requester 1 operand accepted this cycle
//    out_valid    out_data/out_id hold a result
//    out_data     extended result                [OUT_W-1:0]
//    out_id       requester that owns out_data
//    out_ready    consumer takes the result this cycle
// ============================================================================
module sext_arbiter #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [IN_W-1:0]  req0_data,
  input  logic             req0_signed,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IN_W-1:0]  req1_data,
  input  logic             req1_signed,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_id,
  input  logic             out_ready
);

  localparam int c_EXT_W = OUT_W - IN_W;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic             out_id_q,    out_id_d;
  logic             last_grant_q, last_grant_d;

  logic w_can_accept;
  logic w_grant0;
  logic w_grant1;
  logic w_xfer0;
  logic w_xfer1;

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] data,
                                              input logic            sgn);
    extend = {{c_EXT_W{sgn & data[IN_W-1]}}, data};
  endfunction

  // Grant and handshake. On a tie the requester that did not win the last
  // transfer is chosen; last_grant resets to 1 so requester 0 wins first.
  always_comb begin
    w_can_accept = !out_valid_q | out_ready;
    w_grant0     = req0_valid & (!req1_valid | last_grant_q);
    w_grant1     = req1_valid & (!req0_valid | !last_grant_q);
    req0_ready   = w_grant0 & w_can_accept & !rst;
    req1_ready   = w_grant1 & w_can_accept & !rst;
    w_xfer0      = req0_valid & req0_ready;
    w_xfer1      = req1_valid & req1_ready;
  end

  // Output buffer next state. A transfer in the same cycle as a drain simply
  // overwrites the entry, so out_valid never drops between results.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
    if (w_xfer0) begin
      out_valid_d  = 1'b1;
      out_data_d   = extend(req0_data, req0_signed);
      out_id_d     = 1'b0;
      last_grant_d = 1'b0;
    end else if (w_xfer1) begin
      out_valid_d  = 1'b1;
      out_data_d   = extend(req1_data, req1_signed);
      out_id_d     = 1'b1;
      last_grant_d = 1'b1;
    end else if (out_ready) begin
      // Drain: data and id keep their last value.
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule
`default_nettype wire

// File: tb/tb_sext_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sext_arbiter
//  Purpose  : Directed self-checking bench for sext_arbiter (default 3->8
//             instance plus a 12->32 instance for the wide case).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sext_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_signed, req0_ready;
  logic [2:0] req0_data;
  logic       req1_valid, req1_signed, req1_ready;
  logic [2:0] req1_data;
  logic       out_valid, out_id, out_ready;
  logic [7:0] out_data;

  // Wide instance signals
  logic        w0_valid, w0_signed, w0_ready;
  logic [11:0] w0_data;
  logic        w1_valid, w1_signed, w1_ready;
  logic [11:0] w1_data;
  logic        wo_valid, wo_id, wo_ready;
  logic [31:0] wo_data;

  int vectors;
  int miscompares;

  sext_arbiter #(.IN_W(3), .OUT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_signed(req0_signed),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_signed(req1_signed),
    .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready)
  );

  sext_arbiter #(.IN_W(12), .OUT_W(32)) u_dut_wide (
    .clk(clk), .rst(rst),
    .req0_valid(w0_valid), .req0_data(w0_data), .req0_signed(w0_signed),
    .req0_ready(w0_ready),
    .req1_valid(w1_valid), .req1_data(w1_data), .req1_signed(w1_signed),
    .req1_ready(w1_ready),
    .out_valid(wo_valid), .out_data(wo_data), .out_id(wo_id),
    .out_ready(wo_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b data=%h id=%b, want 0 00 0", out_valid, out_data, out_id);
    end
    // Load a result, then hit rst in the middle of the cycle.
    out_ready   = 1'b0;
    req0_valid  = 1'b1;
    req0_data   = 3'b101;
    req0_signed = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hFD) begin
      miscompares++;
      $display("FAIL reset_preload: valid=%b data=%h, want 1 fd", out_valid, out_data);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async: valid=%b data=%h, want 0 00", out_valid, out_data);
    end
    req1_valid = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: r0=%b r1=%b, want 0 0", req0_ready, req1_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: valid=%b r0=%b r1=%b, want 0 0 0", out_valid, req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_sign_ext();
    logic [2:0] d   [4] = '{3'b101, 3'b101, 3'b011, 3'b100};
    logic       s   [4] = '{1'b1,   1'b0,   1'b1,   1'b1};
    logic [7:0] exp [4] = '{8'hFD,  8'h05,  8'h03,  8'hFC};
    out_ready  = 1'b1;
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req0_valid  = 1'b1;
      req0_data   = d[i];
      req0_signed = s[i];
      #1;
      vectors++;
      if (req0_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL sext_ready[%0d]: r0=%b, want 1", i, req0_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_id !== 1'b0) begin
        miscompares++;
        $display("FAIL sext[%0d]: valid=%b data=%h id=%b, want 1 %h 0", i, out_valid, out_data, out_id, exp[i]);
      end
    end
    req0_valid = 1'b0;
  endtask

  // Entry holds 0xFC from requester 0; last grant was 0.
  task automatic test_drain();
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'hFC || out_id !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: valid=%b data=%h id=%b, want 0 fc 0", out_valid, out_data, out_id);
    end
    req0_valid = 1'b1; req0_data = 3'b001; req0_signed = 1'b0;
    req1_valid = 1'b1; req1_data = 3'b010; req1_signed = 1'b0;
    #1;
    vectors++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_tie_grant: r0=%b r1=%b, want 0 1", req0_ready, req1_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h02 || out_id !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_tie_result: valid=%b data=%h id=%b, want 1 02 1", out_valid, out_data, out_id);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_second: valid=%b, want 0", out_valid);
    end
  endtask

  // last grant is 1, so the alternation starts with requester 0.
  task automatic test_round_robin();
    logic       exp_id   [4] = '{1'b0,  1'b1,  1'b0,  1'b1};
    logic [7:0] exp_data [4] = '{8'h02, 8'hFF, 8'h02, 8'hFF};
    out_ready  = 1'b1;
    req0_valid = 1'b1; req0_data = 3'b010; req0_signed = 1'b1;
    req1_valid = 1'b1; req1_data = 3'b111; req1_signed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (req0_ready !== ~exp_id[i] || req1_ready !== exp_id[i]) begin
        miscompares++;
        $display("FAIL rr_ready[%0d]: r0=%b r1=%b, want %b %b", i, req0_ready, req1_ready, ~exp_id[i], exp_id[i]);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_id !== exp_id[i] || out_data !== exp_data[i]) begin
        miscompares++;
        $display("FAIL rr[%0d]: valid=%b id=%b data=%h, want 1 %b %h", i, out_valid, out_id, out_data, exp_id[i], exp_data[i]);
      end
    end
  endtask

  // Entry holds 0xFF from requester 1, both requesters still valid.
  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_ready[%0d]: r0=%b r1=%b, want 0 0", i, req0_ready, req1_ready);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'hFF || out_id !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h id=%b, want 1 ff 1", i, out_valid, out_data, out_id);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release_ready: r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h02 || out_id !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b data=%h id=%b, want 1 02 0", out_valid, out_data, out_id);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_final_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_wide();
    wo_ready  = 1'b1;
    w0_valid  = 1'b1; w0_data = 12'h800; w0_signed = 1'b1;
    tick();
    vectors++;
    if (wo_valid !== 1'b1 || wo_data !== 32'hFFFFF800 || wo_id !== 1'b0) begin
      miscompares++;
      $display("FAIL wide_signed: valid=%b data=%h id=%b, want 1 fffff800 0", wo_valid, wo_data, wo_id);
    end
    w0_valid = 1'b0;
    w1_valid = 1'b1; w1_data = 12'h800; w1_signed = 1'b0;
    tick();
    vectors++;
    if (wo_valid !== 1'b1 || wo_data !== 32'h00000800 || wo_id !== 1'b1) begin
      miscompares++;
      $display("FAIL wide_unsigned: valid=%b data=%h id=%b, want 1 00000800 1", wo_valid, wo_data, wo_id);
    end
    w1_data = 12'h7FF; w1_signed = 1'b1;
    tick();
    vectors++;
    if (wo_data !== 32'h000007FF) begin
      miscompares++;
      $display("FAIL wide_pos: data=%h, want 000007ff", wo_data);
    end
    w1_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    req0_valid  = 1'b0; req0_data = '0; req0_signed = 1'b0;
    req1_valid  = 1'b0; req1_data = '0; req1_signed = 1'b0;
    out_ready   = 1'b0;
    w0_valid    = 1'b0; w0_data = '0; w0_signed = 1'b0;
    w1_valid    = 1'b0; w1_data = '0; w1_signed = 1'b0;
    wo_ready    = 1'b0;
    #1;
    test_reset();
    test_sign_ext();
    test_drain();
    test_round_robin();
    test_backpressure();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
